// File: rtl/candy_ctrl_pkg.sv
// Shared state encodings and reset level for the candy pipeline controller.
// Holds the constants that candy_defines.v carries in the original source tree.
package candy_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Reset is asserted when rst equals this level.
    localparam logic RST_ENABLE = 1'b0;

    localparam int WAIT_CNT_WIDTH = 8;

endpackage

// File: rtl/candy_wait_cnt.sv
// Memory wait counter: counts stalled cycles and flags when the next stall hits the limit.
module candy_wait_cnt
    import candy_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      inc,
    input  logic [WAIT_CNT_WIDTH-1:0] limit,
    output logic                      expired
);

    logic [WAIT_CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WAIT_CNT_WIDTH'(1);
        end
    end

    // Fires in the stalled cycle whose increment would bring the count up to the limit.
    assign expired = inc && (count == limit - WAIT_CNT_WIDTH'(1));

endmodule

// File: rtl/candy_ctrl.sv
// Multi-cycle pipeline controller: FSM, program counter and retire counter.
// Optional memory-wait timeout is enabled by defining CANDY_CTRL_TIMEOUT_EN.
module candy_ctrl
    import candy_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int PC_STEP     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                halt_req,
    input  logic                need_mem,
    input  logic                mem_ready,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    output logic                if_enable,
    output logic                id_enable,
    output logic                ex_enable,
    output logic                mem_enable,
    output logic                wb_enable,
    output logic [PC_WIDTH-1:0] pc,
    output logic [2:0]          state,
    output logic                busy,
    output logic [15:0]         retired,
    output logic                timeout_err
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         retired_q;
    logic                wait_expired;

`ifdef CANDY_CTRL_TIMEOUT_EN
    logic wait_state;
    logic timeout_err_q;

    assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

    candy_wait_cnt u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wait_state),
        .inc     (wait_state && !mem_ready),
        .limit   (WAIT_CNT_WIDTH'(MEM_TIMEOUT)),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            timeout_err_q <= 1'b0;
        end else if (wait_expired) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // NOTE: non-blocking assignments let every register see pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WB) begin
                pc_q      <= pc_load ? pc_target : pc_q + PC_WIDTH'(PC_STEP);
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        if_enable  = 1'b0;
        id_enable  = 1'b0;
        ex_enable  = 1'b0;
        mem_enable = 1'b0;
        wb_enable  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if_enable = 1'b1;
                if (mem_ready)         state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_HALT;
            end
            ST_DECODE: begin
                id_enable = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                ex_enable = 1'b1;
                state_d   = need_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_enable = 1'b1;
                if (mem_ready)         state_d = ST_WB;
                else if (wait_expired) state_d = ST_HALT;
            end
            ST_WB: begin
                wb_enable = 1'b1;
                state_d   = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                busy = 1'b0;
                if (!halt_req && run) state_d = ST_FETCH;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state   = state_q;
    assign pc      = pc_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_candy_ctrl.sv
// Randomized self-checking bench for candy_ctrl against an instruction-level reference model.
module tb_candy_ctrl;

    localparam int PC_W = 8;
    localparam int TMO  = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run = 1'b0;
    logic            halt_req = 1'b0;
    logic            need_mem = 1'b0;
    logic            mem_ready = 1'b0;
    logic            pc_load = 1'b0;
    logic [PC_W-1:0] pc_target = '0;
    logic            if_enable, id_enable, ex_enable, mem_enable, wb_enable;
    logic [PC_W-1:0] pc;
    logic [2:0]      state;
    logic            busy;
    logic [15:0]     retired;
    logic            timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pc      = 0;
    int exp_retired = 0;
    bit exp_err     = 1'b0;

    candy_ctrl #(.PC_WIDTH(PC_W), .PC_STEP(1), .MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt_req    (halt_req),
        .need_mem    (need_mem),
        .mem_ready   (mem_ready),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .if_enable   (if_enable),
        .id_enable   (id_enable),
        .ex_enable   (ex_enable),
        .mem_enable  (mem_enable),
        .wb_enable   (wb_enable),
        .pc          (pc),
        .state       (state),
        .busy        (busy),
        .retired     (retired),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs that only matter in particular phases get random values everywhere else.
    task automatic noise();
        run       = 1'($urandom);
        halt_req  = 1'($urandom);
        need_mem  = 1'($urandom);
        mem_ready = 1'($urandom);
        pc_load   = 1'($urandom);
        pc_target = PC_W'($urandom);
    endtask

    // Expected stage enables {if, id, ex, mem, wb} for each phase code.
    function automatic logic [4:0] exp_en(input int s);
        case (s)
            1:       return 5'b10000;
            2:       return 5'b01000;
            3:       return 5'b00100;
            4:       return 5'b00010;
            5:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check_cycle(input int s);
        check("state", 32'(state), 32'(s));
        check("enables", 32'({if_enable, id_enable, ex_enable, mem_enable, wb_enable}), 32'(exp_en(s)));
        check("busy", 32'(busy), 32'(s != 0 && s != 6));
        check("pc", 32'(pc), 32'(exp_pc));
        check("retired", 32'(retired), 32'(exp_retired));
        check("timeout_err", 32'(timeout_err), 32'(exp_err));
    endtask

    // Stall n_wait cycles in a memory phase, then complete.
    task automatic do_wait(input int s, input int n_wait);
        for (int i = 0; i < n_wait; i++) begin
            noise();
            mem_ready = 1'b0;
            check_cycle(s);
            step();
        end
        noise();
        mem_ready = 1'b1;
        check_cycle(s);
        step();
    endtask

    task automatic leave_halt();
        for (int k = 0; k < 2; k++) begin
            noise();
            halt_req = 1'b1;
            step();
            check_cycle(6);
        end
        noise();
        halt_req = 1'b0;
        run      = 1'b0;
        step();
        check_cycle(6);
        noise();
        halt_req = 1'b0;
        run      = 1'b1;
        step();
        check_cycle(1);
    endtask

    task automatic front_end(input bit use_mem);
        do_wait(1, 0);
        noise();
        check_cycle(2);
        step();
        noise();
        need_mem = use_mem;
        check_cycle(3);
        step();
    endtask

    // One full instruction starting from FETCH; the model updates pc/retired at writeback.
    task automatic run_instr(input int fw, input bit use_mem, input int mw,
                             input bit load, input logic [PC_W-1:0] tgt, input bit halt);
        do_wait(1, fw);
        noise();
        check_cycle(2);
        step();
        noise();
        need_mem = use_mem;
        check_cycle(3);
        step();
        if (use_mem) do_wait(4, mw);
        noise();
        halt_req  = halt;
        pc_load   = load;
        pc_target = tgt;
        check_cycle(5);
        step();
        exp_pc      = load ? int'(tgt) : (exp_pc + 1) % (1 << PC_W);
        exp_retired = (exp_retired + 1) % 65536;
        if (halt) begin
            check_cycle(6);
            leave_halt();
        end
    endtask

`ifdef CANDY_CTRL_TIMEOUT_EN
    task automatic timeout_instr(input bit in_mem);
        int s;
        s = in_mem ? 4 : 1;
        if (in_mem) front_end(1'b1);
        for (int i = 0; i < TMO; i++) begin
            noise();
            mem_ready = 1'b0;
            check_cycle(s);
            step();
        end
        exp_err = 1'b1;
        check_cycle(6);
        leave_halt();
    endtask
`endif

    initial begin
        noise();
        rst = 1'b0;
        step();
        noise();
        step();
        check_cycle(0);

        rst = 1'b1;
        noise();
        run = 1'b0;
        step();
        check_cycle(0);
        noise();
        run = 1'b1;
        step();
        check_cycle(1);

        // Back-to-back zero-wait instructions, then one with a 3-cycle data stall.
        for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 0, 1'b0, '0, 1'b0);
        run_instr(0, 1'b1, 3, 1'b0, '0, 1'b0);

        // Redirect, wrap of the pc, and a halt/resume.
        run_instr(0, 1'b0, 0, 1'b1, 8'h40, 1'b0);
        run_instr(1, 1'b0, 0, 1'b1, 8'hFF, 1'b0);
        run_instr(0, 1'b0, 0, 1'b0, '0, 1'b0);
        run_instr(0, 1'b0, 0, 1'b0, '0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_instr($urandom_range(0, 4), 1'($urandom), $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0), PC_W'($urandom), ($urandom_range(0, 4) == 0));
        end

        // Reset in the middle of a data stall.
        front_end(1'b1);
        for (int i = 0; i < 2; i++) begin
            noise();
            mem_ready = 1'b0;
            check_cycle(4);
            step();
        end
        noise();
        rst = 1'b0;
        step();
        exp_pc      = 0;
        exp_retired = 0;
        exp_err     = 1'b0;
        check_cycle(0);
        rst = 1'b1;
        noise();
        run = 1'b0;
        step();
        check_cycle(0);
        run = 1'b1;
        step();
        check_cycle(1);
        run_instr(2, 1'b1, 1, 1'b0, '0, 1'b0);

`ifdef CANDY_CTRL_TIMEOUT_EN
        run_instr(TMO - 1, 1'b1, TMO - 1, 1'b0, '0, 1'b0);
        timeout_instr(1'b0);
        run_instr(1, 1'b0, 0, 1'b0, '0, 1'b0);
        timeout_instr(1'b1);
        run_instr(0, 1'b1, 2, 1'b0, '0, 1'b0);
`else
        run_instr(40, 1'b1, 40, 1'b0, '0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
